// File: rtl/jailbreak.sv
// Shared types and constants for the jailbreak DIP/config bank.
package jailbreak;

    localparam int unsigned DIP_WORD_W = 32;
    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned DIP_OFS_W  = 8;

    typedef logic [DIP_WORD_W-1:0] dip_word_t;
    typedef logic [DIP_OFS_W-1:0]  dip_ofs_t;

    localparam dip_ofs_t DIP_BANK_ACTIVE_OFS = 8'h40;
    localparam dip_ofs_t DIP_BANK_CTRL_OFS   = 8'hFF;

    // CTRL write-data bit positions
    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_REVERT_BIT = 1;
    localparam int unsigned CTRL_LOCK_BIT   = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        APPLY = 2'd2
    } dip_bank_state_t;

    // CTRL read-back word
    typedef struct packed {
        logic                  lock;
        logic [DIP_WORD_W-3:0] rsvd;
        logic                  pending;
    } dip_ctrl_status_t;

endpackage

// File: rtl/bus_if.sv
// Simple register bridge: single-cycle writes, reads answered one cycle later.
interface bus_if;
    import jailbreak::*;

    logic [BUS_ADDR_W-1:0] addr;
    logic                  wr;
    dip_word_t             wr_data;
    logic                  rd;
    dip_word_t             rd_data;
    logic                  rd_data_valid;

    modport master (
        output addr, wr, wr_data, rd,
        input  rd_data, rd_data_valid
    );

    modport slave (
        input  addr, wr, wr_data, rd,
        output rd_data, rd_data_valid
    );

endinterface

// File: rtl/jailbreak_dip_word.sv
// One shadow/active DIP word pair; changed pulses when an apply alters the active value.
module jailbreak_dip_word
    import jailbreak::*;
#(
    parameter dip_word_t DEFAULT = '0
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      shadow_we,
    input  dip_word_t shadow_wdata,
    input  logic      revert,
    input  logic      apply,
    output dip_word_t shadow,
    output dip_word_t active,
    output logic      changed
);

    // apply samples the shadow as it stood before any write landing on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= DEFAULT;
            active  <= DEFAULT;
            changed <= 1'b0;
        end else begin
            changed <= apply && (active != shadow);
            if (apply) begin
                active <= shadow;
            end
            if (revert) begin
                shadow <= active;
            end else if (shadow_we) begin
                shadow <= shadow_wdata;
            end
        end
    end

endmodule

// File: rtl/jailbreak_dip_bank.sv
// NUM_REGS DIP/config words behind one bridge slave, with atomic (optionally deferred) commit.
// Optional sticky write lock when JAILBREAK_DIP_LOCK_EN is defined.
module jailbreak_dip_bank
    import jailbreak::*;
#(
    parameter int unsigned NUM_REGS            = 4,
    parameter bit          DEFERRED            = 1'b1,
    parameter dip_word_t   DEFAULTS [NUM_REGS] = '{default: '0}
) (
    input  logic                clk,
    input  logic                reset_n,
    bus_if.slave                bridge,
    input  logic                apply_strobe,
    output dip_word_t           dip_switches [NUM_REGS],
    output logic [NUM_REGS-1:0] changed,
    output logic                pending
);

    dip_bank_state_t     state;
    dip_bank_state_t     state_next;
    dip_ofs_t            ofs;
    dip_word_t           shadow [NUM_REGS];
    dip_word_t           rd_mux;
    dip_ctrl_status_t    status;
    logic [NUM_REGS-1:0] shadow_we;
    logic                lock;
    logic                ctrl_wr_c;
    logic                commit_q;
    logic                revert_q;
    logic                apply_c;
    logic                pending_d;
    logic                unused_addr_bits;

    assign ofs              = bridge.addr[9:2];
    assign unused_addr_bits = ^{bridge.addr[BUS_ADDR_W-1:10], bridge.addr[1:0]};
    assign ctrl_wr_c        = bridge.wr && (ofs == DIP_BANK_CTRL_OFS) && !lock;

`ifdef JAILBREAK_DIP_LOCK_EN
    // sticky lock, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock <= 1'b0;
        end else if (bridge.wr && (ofs == DIP_BANK_CTRL_OFS) && bridge.wr_data[CTRL_LOCK_BIT]) begin
            lock <= 1'b1;
        end
    end
`else
    assign lock = 1'b0;
`endif

    // CTRL requests are registered; revert overrides a commit in the same write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_q <= 1'b0;
            revert_q <= 1'b0;
        end else begin
            commit_q <= ctrl_wr_c && bridge.wr_data[CTRL_COMMIT_BIT] && !bridge.wr_data[CTRL_REVERT_BIT];
            revert_q <= ctrl_wr_c && bridge.wr_data[CTRL_REVERT_BIT];
        end
    end

    always_comb begin
        shadow_we = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            shadow_we[i] = bridge.wr && !lock && (ofs == dip_ofs_t'(i));
        end
    end

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_word
        jailbreak_dip_word #(
            .DEFAULT (DEFAULTS[i])
        ) u_word (
            .clk          (clk),
            .reset_n      (reset_n),
            .shadow_we    (shadow_we[i]),
            .shadow_wdata (bridge.wr_data),
            .revert       (revert_q),
            .apply        (apply_c),
            .shadow       (shadow[i]),
            .active       (dip_switches[i]),
            .changed      (changed[i])
        );
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_d;
        end
    end

    // next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (commit_q) begin
                    state_next = DEFERRED ? WAIT : APPLY;
                end
            end
            WAIT: begin
                if (revert_q) begin
                    state_next = IDLE;
                end else if (apply_strobe) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                if (commit_q) begin
                    state_next = DEFERRED ? WAIT : APPLY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // active words load on the edge entering APPLY, so APPLY shows the new values and changed
    always_comb begin
        apply_c   = 1'b0;
        pending_d = 1'b0;
        apply_c   = (state_next == APPLY);
        pending_d = (state_next == WAIT);
    end

    always_comb begin
        status         = '0;
        status.lock    = lock;
        status.pending = pending;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ofs == dip_ofs_t'(i)) begin
                rd_mux = shadow[i];
            end
            if (ofs == DIP_BANK_ACTIVE_OFS + dip_ofs_t'(i)) begin
                rd_mux = dip_switches[i];
            end
        end
        if (ofs == DIP_BANK_CTRL_OFS) begin
            rd_mux = dip_word_t'(status);
        end
    end

    // registered read port; a same-cycle write is not yet visible
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bridge.rd_data       <= '0;
            bridge.rd_data_valid <= 1'b0;
        end else begin
            bridge.rd_data       <= bridge.rd ? rd_mux : '0;
            bridge.rd_data_valid <= bridge.rd;
        end
    end

endmodule
